// File: rtl/wb_regfile_pkg.sv
// Shared constants and write-back select encoding for the WB stage / register file.
package wb_regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;
  localparam int LINK_REG = 31;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2
  } wb_sel_e;
endpackage

// File: rtl/wb_regfile_select.sv
// Combinational write-back mux: picks data, destination and effective enable.
module wb_select
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W   = wb_regfile_pkg::ADDR_W,
  parameter int LINK_REG = wb_regfile_pkg::LINK_REG
) (
  input  logic              rst,
  input  logic              memtoreg,
  input  logic              regwrite,
  input  logic              jalr,
  input  logic              jald,
  input  logic [DATA_W-1:0] pc_add,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dst,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] wreg,
  output logic              wen
);
  wb_sel_e sel;

  always_comb begin
    sel = WB_SEL_ALU;
    if (jald | jalr) sel = WB_SEL_LINK;
    else if (memtoreg) sel = WB_SEL_MEM;
  end

  always_comb begin
    wdata = alu;
    case (sel)
      WB_SEL_LINK: wdata = pc_add;
      WB_SEL_MEM:  wdata = rdata;
      default:     wdata = alu;
    endcase
  end

  // jal overrides the destination even if jalr is also set
  assign wreg = jald ? ADDR_W'(LINK_REG) : dst;
  assign wen  = (regwrite | jald) & (wreg != ADDR_W'(REG_ZERO)) & ~rst;
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage merged with the architectural register file; two write-first read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W   = wb_regfile_pkg::ADDR_W,
  parameter int LINK_REG = wb_regfile_pkg::LINK_REG
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WBmemtoreg,
  input  logic              WBregwrite,
  input  logic              WBcntrljalr,
  input  logic              WBcntrljald,
  input  logic [DATA_W-1:0] WBPCAddResult,
  input  logic [DATA_W-1:0] WBAluResult,
  input  logic [DATA_W-1:0] WBReadData,
  input  logic [ADDR_W-1:0] WBRegDst,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] WriteReg,
  output logic              WriteEn
);
  localparam int NREGS  = 1 << ADDR_W;
  localparam int NPORTS = 2;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NPORTS-1:0][ADDR_W-1:0] ra;
  logic [NPORTS-1:0][DATA_W-1:0] rd;

  wb_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK_REG)) u_sel (
    .rst      (Reset),
    .memtoreg (WBmemtoreg),
    .regwrite (WBregwrite),
    .jalr     (WBcntrljalr),
    .jald     (WBcntrljald),
    .pc_add   (WBPCAddResult),
    .alu      (WBAluResult),
    .rdata    (WBReadData),
    .dst      (WBRegDst),
    .wdata    (WriteData),
    .wreg     (WriteReg),
    .wen      (WriteEn)
  );

  // WriteEn is already low for reg 0 and during reset, so only reset needs priority here
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (WriteEn) begin
      regs[WriteReg] <= WriteData;
    end
  end

  assign ra = {ReadReg2, ReadReg1};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    always_comb begin
      rd[p] = regs[ra[p]];
      if (ra[p] == ADDR_W'(REG_ZERO)) rd[p] = '0;
      else if (WriteEn && (WriteReg == ra[p])) rd[p] = WriteData;
    end
  end

  assign ReadData1 = rd[0];
  assign ReadData2 = rd[1];
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_wb_regfile;
  logic        Clk = 1'b0;
  logic        Reset, WBmemtoreg, WBregwrite, WBcntrljalr, WBcntrljald;
  logic [31:0] WBPCAddResult, WBAluResult, WBReadData;
  logic [4:0]  WBRegDst, ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic [4:0]  WriteReg;
  logic        WriteEn;

  always #5 Clk = ~Clk;

  wb_regfile dut (
    .Clk(Clk), .Reset(Reset), .WBmemtoreg(WBmemtoreg), .WBregwrite(WBregwrite),
    .WBcntrljalr(WBcntrljalr), .WBcntrljald(WBcntrljald), .WBPCAddResult(WBPCAddResult),
    .WBAluResult(WBAluResult), .WBReadData(WBReadData), .WBRegDst(WBRegDst),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteData(WriteData), .WriteReg(WriteReg), .WriteEn(WriteEn)
  );

  typedef struct {
    logic rst, mtr, rw, jalr, jald;
    logic [31:0] pc, alu, rdat;
    logic [4:0] dst, r1, r2;
  } stim_t;

  typedef struct {
    string name;
    logic [31:0] rd1, rd2, wdata;
    logic [4:0] wreg;
    logic wen;
    bit chk_w;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  function automatic stim_t wr(input logic rst, rw, mtr, jalr, jald, input logic [4:0] dst,
                               input logic [31:0] alu, rdat, pc, input logic [4:0] r1, r2);
    stim_t s;
    s.rst = rst; s.rw = rw; s.mtr = mtr; s.jalr = jalr; s.jald = jald; s.dst = dst;
    s.alu = alu; s.rdat = rdat; s.pc = pc; s.r1 = r1; s.r2 = r2;
    return s;
  endfunction

  function automatic stim_t rd(input logic [4:0] r1, r2);
    return wr(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, r1, r2);
  endfunction

  function automatic exp_t ex(input string name, input logic [31:0] rd1, rd2, input logic wen,
                              input bit chk_w, input logic [4:0] wreg, input logic [31:0] wdata);
    exp_t e;
    e.name = name; e.rd1 = rd1; e.rd2 = rd2; e.wen = wen;
    e.chk_w = chk_w; e.wreg = wreg; e.wdata = wdata;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    Reset = s.rst; WBregwrite = s.rw; WBmemtoreg = s.mtr; WBcntrljalr = s.jalr;
    WBcntrljald = s.jald; WBRegDst = s.dst; WBAluResult = s.alu; WBReadData = s.rdat;
    WBPCAddResult = s.pc; ReadReg1 = s.r1; ReadReg2 = s.r2;
  endtask

  task automatic step(input stim_t s, input exp_t e);
    @(posedge Clk); #1;
    drive(s);
    sbq.push_back(e);
  endtask

  task automatic cmp(input string name, input string fld, input logic [31:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", name, fld, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp(e.name, "ReadData1", ReadData1, e.rd1);
        cmp(e.name, "ReadData2", ReadData2, e.rd2);
        cmp(e.name, "WriteEn", {31'b0, WriteEn}, {31'b0, e.wen});
        if (e.chk_w) begin
          cmp(e.name, "WriteReg", {27'b0, WriteReg}, {27'b0, e.wreg});
          cmp(e.name, "WriteData", WriteData, e.wdata);
        end
      end
    end
  end

  initial begin : stim
    drive(wr(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0));
    repeat (2) @(posedge Clk);
    // still in reset, registers already cleared
    step(wr(1, 0, 0, 0, 0, 5'd4, 32'h0, 32'h0, 32'h0, 5'd4, 5'd31), ex("in_reset", 0, 0, 0, 1, 5'd4, 32'h0));
    for (int i = 0; i < 32; i++)
      step(rd(5'(i), 5'(31 - i)), ex("reset_read", 0, 0, 0, 0, 5'd0, 32'h0));

    step(wr(0, 1, 0, 0, 0, 5'd8, 32'h0000_1234, 32'h0, 32'h0, 5'd8, 5'd0),
         ex("alu_bypass", 32'h0000_1234, 0, 1, 1, 5'd8, 32'h0000_1234));
    step(rd(5'd8, 5'd9), ex("alu_stored", 32'h0000_1234, 0, 0, 0, 5'd0, 32'h0));

    step(wr(0, 1, 1, 0, 0, 5'd9, 32'h4, 32'hDEAD_BEEF, 32'h0, 5'd1, 5'd9),
         ex("load_bypass", 0, 32'hDEAD_BEEF, 1, 1, 5'd9, 32'hDEAD_BEEF));
    step(rd(5'd9, 5'd8), ex("load_stored", 32'hDEAD_BEEF, 32'h0000_1234, 0, 0, 5'd0, 32'h0));

    step(wr(0, 0, 0, 0, 1, 5'd5, 32'h0, 32'h0, 32'h0040_0010, 5'd31, 5'd5),
         ex("jal", 32'h0040_0010, 0, 1, 1, 5'd31, 32'h0040_0010));
    step(rd(5'd31, 5'd5), ex("jal_stored", 32'h0040_0010, 0, 0, 0, 5'd0, 32'h0));

    step(wr(0, 1, 0, 1, 0, 5'd12, 32'h99, 32'h0, 32'h20, 5'd12, 5'd0),
         ex("jalr", 32'h20, 0, 1, 1, 5'd12, 32'h20));
    step(rd(5'd12, 5'd31), ex("jalr_stored", 32'h20, 32'h0040_0010, 0, 0, 5'd0, 32'h0));

    // jalr without regwrite commits nothing
    step(wr(0, 0, 0, 1, 0, 5'd13, 32'h0, 32'h0, 32'h30, 5'd13, 5'd0),
         ex("jalr_norw", 0, 0, 0, 1, 5'd13, 32'h30));
    step(rd(5'd13, 5'd12), ex("jalr_norw_st", 0, 32'h20, 0, 0, 5'd0, 32'h0));

    step(wr(0, 1, 0, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0),
         ex("r0_write", 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF));
    step(rd(5'd0, 5'd0), ex("r0_stored", 0, 0, 0, 0, 5'd0, 32'h0));

    step(wr(0, 0, 1, 1, 1, 5'd6, 32'h11, 32'h22, 32'h44, 5'd31, 5'd6),
         ex("jal_jalr", 32'h44, 0, 1, 1, 5'd31, 32'h44));
    step(rd(5'd31, 5'd6), ex("jal_jalr_st", 32'h44, 0, 0, 0, 5'd0, 32'h0));

    step(wr(1, 1, 0, 0, 0, 5'd3, 32'h55, 32'h0, 32'h0, 5'd3, 5'd8),
         ex("reset_write", 0, 32'h0000_1234, 0, 1, 5'd3, 32'h55));
    step(rd(5'd3, 5'd8), ex("reset_clear", 0, 0, 0, 0, 5'd0, 32'h0));
    step(rd(5'd31, 5'd9), ex("reset_clear2", 0, 0, 0, 0, 5'd0, 32'h0));

    step(wr(0, 1, 0, 0, 0, 5'd7, 32'h77, 32'h0, 32'h0, 5'd7, 5'd7),
         ex("dual_bypass", 32'h77, 32'h77, 1, 1, 5'd7, 32'h77));
    step(rd(5'd7, 5'd7), ex("dual_stored", 32'h77, 32'h77, 0, 0, 5'd0, 32'h0));

    repeat (4) @(negedge Clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage consumer of the MEM/WB pipeline register, merged with the architectural register file.
- Selects the write-back data (ALU result, load data, or link address) and the destination register.
- Commits the write on the rising clock edge.
- Serves the ID stage's two combinational read ports, with write-first bypass, so there is no WB-to-ID hazard.
- Exports the committed write (enable, register, data) for the forwarding unit.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2^ADDR_W registers)
- LINK_REG, 31, destination forced for jal-style link writes

Ports:
- Clk  in  1  system clock, all state updates on posedge
- Reset  in  1  synchronous, active-high; clears the register file
- WBmemtoreg  in  1  1 = write load data, 0 = write ALU result
- WBregwrite  in  1  register write enable from the WB pipeline stage
- WBcntrljalr  in  1  jalr link write: data = PC+4, dest = WBRegDst
- WBcntrljald  in  1  jal link write: data = PC+4, dest = LINK_REG
- WBPCAddResult  in  DATA_W  PC+4 of the instruction in WB
- WBAluResult  in  DATA_W  ALU result
- WBReadData  in  DATA_W  data memory load result
- WBRegDst  in  ADDR_W  destination register index
- ReadReg1  in  ADDR_W  ID read port 1 index (rs)
- ReadReg2  in  ADDR_W  ID read port 2 index (rt)
- ReadData1  out  DATA_W  read port 1 data
- ReadData2  out  DATA_W  read port 2 data
- WriteData  out  DATA_W  selected write-back data (combinational)
- WriteReg  out  ADDR_W  effective destination index (combinational)
- WriteEn  out  1  effective write enable (combinational), for the forwarding unit

Behaviour:
- Clock and reset: one clock Clk; Reset is synchronous and active-high.
- Data select, priority order:
  - (WBcntrljald | WBcntrljalr) → WBPCAddResult
  - else WBmemtoreg → WBReadData
  - else → WBAluResult
- Destination: WBcntrljald → LINK_REG; else WBRegDst.
- Enable: WriteEn = (WBregwrite | WBcntrljald) & (WriteReg != 0) & ~Reset.
- Commit: at posedge Clk, if WriteEn then regs[WriteReg] <= WriteData.
  - One-cycle latency; the value is architecturally visible from the next cycle.
- Register 0: always reads 0; writes to it are discarded, and WriteEn reads 0 for such a write.
- Read ports are combinational, with write-first bypass:
  - ReadDataN = 0 if ReadRegN == 0
  - else WriteData if WriteEn & (WriteReg == ReadRegN)
  - else regs[ReadRegN]
- Both read ports may address the same register or the write target simultaneously; each resolves independently by the rule above.
- Reset:
  - At posedge with Reset=1, all 2^ADDR_W registers are cleared to 0.
  - Reset takes priority over a concurrent write; that write is lost.
  - While Reset=1, WriteEn=0, so bypass is inhibited and reads return stored values.
  - Reset asserted mid-program clears all state in one cycle; no partial state is kept.
- Illegal case, WBcntrljald & WBcntrljalr both set: resolved deterministically.
  - Destination is LINK_REG and data is WBPCAddResult.
  - No assertion is raised in RTL.
- Outputs after reset, with no write pending: ReadData1/2 = 0 for any index, WriteEn = 0.
  - WriteData and WriteReg always follow their inputs combinationally.
- No X propagation: all state is reset, and the combinational outputs depend only on inputs and state.

Decomposition:
- Shared package holds:
  - constants REG_ZERO=0, LINK_REG=31, DATA_W=32, ADDR_W=5
  - write-back select encoding: WB_SEL_ALU, WB_SEL_MEM, WB_SEL_LINK
- One natural sub-module: wb_select, the purely combinational data/destination/enable mux.
- The storage array and bypass stay in wb_regfile.

Test Plan:
- Reset, then read all 32 indices on both ports → all return 0; WriteEn=0.
- WBregwrite=1, WBmemtoreg=0, WBRegDst=8, WBAluResult=0x0000_1234, ReadReg1=8 in the same cycle → ReadData1=0x0000_1234 before the edge via bypass; after the edge it reads 0x0000_1234 from storage.
- WBmemtoreg=1, WBReadData=0xDEAD_BEEF, WBAluResult=0x4, dest 9 → reg 9 = 0xDEAD_BEEF.
- WBcntrljald=1, WBregwrite=0, WBRegDst=5, WBPCAddResult=0x0040_0010 → WriteReg=31, WriteEn=1, reg 31 = 0x0040_0010, reg 5 unchanged.
- WBcntrljalr=1, WBRegDst=12, WBPCAddResult=0x20 → reg 12 = 0x20.
- Write dest 0 with 0xFFFF_FFFF → WriteEn=0, ReadData1(0)=0.
- Reset=1 together with a write of 0x55 to reg 3 → reg 3 = 0 after the edge, and no bypass during reset.
- ReadReg1=ReadReg2=7 during a write of 0x77 to reg 7 → both ports return 0x77.
